// File: rtl/reg_commit_ctrl_pkg.sv
// Shared constants for the commit controller: controller state encoding,
// default ROB index width and post-flush recovery length.
package reg_commit_ctrl_pkg;

  localparam int ROB_W_DEF       = 4;
  localparam int RECOVER_CYC_DEF = 2;
  localparam int CNT_W           = 4;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  // Register x0 is hardwired, so writes or renames targeting it are dropped.
  function automatic logic isRealReg(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage

// File: rtl/reg_commit_ctrl_if.sv
// Bundle of the ROB head, decoder rename, register file and fetch redirect
// signals around the commit controller. The master side is the surrounding
// pipeline and the slave side is the controller.
interface reg_commit_ctrl_if
  import reg_commit_ctrl_pkg::*;
#(
  parameter int ROB_W = ROB_W_DEF
) ();

  logic             rdy;
  logic             head_valid;
  logic [ROB_W-1:0] head_rob_id;
  logic [4:0]       head_rd;
  logic [31:0]      head_value;
  logic             head_mispredict;
  logic [31:0]      head_target;
  logic             head_pop;

  logic             ren_valid;
  logic [4:0]       ren_rd;
  logic [ROB_W-1:0] ren_rob_id;
  logic             ren_stall;

  logic             need_set_reg_value;
  logic [4:0]       set_value_reg_id;
  logic [31:0]      set_val;
  logic [ROB_W-1:0] set_reg_rob_id;
  logic             need_set_reg_dep;
  logic [4:0]       set_dep_reg_id;
  logic [ROB_W-1:0] set_dep_rob_id;
  logic             clear;

  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      retired_cnt;

  modport master (
    output rdy, head_valid, head_rob_id, head_rd, head_value,
           head_mispredict, head_target, ren_valid, ren_rd, ren_rob_id,
    input  head_pop, ren_stall, need_set_reg_value, set_value_reg_id,
           set_val, set_reg_rob_id, need_set_reg_dep, set_dep_reg_id,
           set_dep_rob_id, clear, redirect_valid, redirect_pc, retired_cnt
  );

  modport slave (
    input  rdy, head_valid, head_rob_id, head_rd, head_value,
           head_mispredict, head_target, ren_valid, ren_rd, ren_rob_id,
    output head_pop, ren_stall, need_set_reg_value, set_value_reg_id,
           set_val, set_reg_rob_id, need_set_reg_dep, set_dep_reg_id,
           set_dep_rob_id, clear, redirect_valid, redirect_pc, retired_cnt
  );

endinterface

// File: rtl/reg_commit_ctrl.sv
// Commit controller: retires the ROB head into the register file, forwards
// decoder renames as dependency writes, and on a mispredicted head clears
// all dependencies, redirects fetch and holds renames off while the
// pipeline recovers.
module reg_commit_ctrl
  import reg_commit_ctrl_pkg::*;
#(
  parameter int ROB_W       = ROB_W_DEF,
  parameter int RECOVER_CYC = RECOVER_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  reg_commit_ctrl_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] recCnt_q, recCnt_d;

  logic             valWrite_q;
  logic [4:0]       valReg_q;
  logic [31:0]      valData_q;
  logic [ROB_W-1:0] valRob_q;
  logic             depWrite_q;
  logic [4:0]       depReg_q;
  logic [ROB_W-1:0] depRob_q;
  logic             clear_q;
  logic             redirect_q;
  logic [31:0]      redirectPc_q;
  logic [31:0]      retiredCnt_q;

  logic inRun;
  logic headPop;
  logic mispPop;
  logic renStall;
  logic renAccept;

  // Pop and stall decisions made within the cycle; a mispredicting pop also
  // stalls the decoder because anything it renames now is wrong-path.
  always_comb begin
    inRun     = (state_q == ST_RUN);
    headPop   = bus.rdy & bus.head_valid & inRun;
    mispPop   = headPop & bus.head_mispredict;
    renStall  = ~inRun | mispPop;
    renAccept = bus.rdy & bus.ren_valid & ~renStall;
  end

  // Next state and recovery counter; rdy low freezes both.
  always_comb begin
    state_d  = state_q;
    recCnt_d = recCnt_q;
    if (bus.rdy) begin
      case (state_q)
        ST_RUN: begin
          if (mispPop) begin
            state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state_d  = ST_RECOVER;
          recCnt_d = CNT_W'(RECOVER_CYC);
        end
        ST_RECOVER: begin
          if (recCnt_q != '0) begin
            recCnt_d = recCnt_q - CNT_W'(1);
          end
          if (recCnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d  = ST_RUN;
          recCnt_d = '0;
        end
      endcase
    end
  end

  // Registered write-back, rename, flush and redirect outputs plus the
  // retirement count; pulses drop while rdy is low, data fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      recCnt_q     <= '0;
      valWrite_q   <= 1'b0;
      valReg_q     <= '0;
      valData_q    <= '0;
      valRob_q     <= '0;
      depWrite_q   <= 1'b0;
      depReg_q     <= '0;
      depRob_q     <= '0;
      clear_q      <= 1'b0;
      redirect_q   <= 1'b0;
      redirectPc_q <= '0;
      retiredCnt_q <= '0;
    end else if (!bus.rdy) begin
      valWrite_q <= 1'b0;
      depWrite_q <= 1'b0;
      clear_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      recCnt_q   <= recCnt_d;
      valWrite_q <= headPop & isRealReg(bus.head_rd);
      depWrite_q <= renAccept & isRealReg(bus.ren_rd);
      clear_q    <= mispPop;
      redirect_q <= mispPop;
      if (headPop) begin
        valReg_q     <= bus.head_rd;
        valData_q    <= bus.head_value;
        valRob_q     <= bus.head_rob_id;
        retiredCnt_q <= retiredCnt_q + 32'd1;
      end
      if (renAccept) begin
        depReg_q <= bus.ren_rd;
        depRob_q <= bus.ren_rob_id;
      end
      if (mispPop) begin
        redirectPc_q <= bus.head_target;
      end
    end
  end

  assign bus.head_pop           = headPop;
  assign bus.ren_stall          = renStall;
  assign bus.need_set_reg_value = valWrite_q;
  assign bus.set_value_reg_id   = valReg_q;
  assign bus.set_val            = valData_q;
  assign bus.set_reg_rob_id     = valRob_q;
  assign bus.need_set_reg_dep   = depWrite_q;
  assign bus.set_dep_reg_id     = depReg_q;
  assign bus.set_dep_rob_id     = depRob_q;
  assign bus.clear              = clear_q;
  assign bus.redirect_valid     = redirect_q;
  assign bus.redirect_pc        = redirectPc_q;
  assign bus.retired_cnt        = retiredCnt_q;

endmodule

// File: tb/tb_reg_commit_ctrl.sv
// Bench for reg_commit_ctrl: a directed vector table, hand-written
// mispredict/recovery sequences and a randomized run against a
// cycle-level reference model of the retirement rules.
module tb_reg_commit_ctrl;

  localparam int ROB_W = 4;
  localparam int REC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reg_commit_ctrl_if #(.ROB_W(ROB_W)) bus ();

  reg_commit_ctrl #(.ROB_W(ROB_W), .RECOVER_CYC(REC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rdy;
    logic        hv;
    logic [3:0]  hid;
    logic [4:0]  hrd;
    logic [31:0] hval;
    logic        hmis;
    logic [31:0] htgt;
    logic        rv;
    logic [4:0]  rrd;
    logic [3:0]  rid;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        ePop;
    logic        eStall;
    logic        eWv;
    logic [4:0]  eWreg;
    logic [31:0] eWval;
    logic [3:0]  eWrob;
    logic        eDv;
    logic [4:0]  eDreg;
    logic [3:0]  eDrob;
    logic        eClr;
    logic [31:0] eCnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the remaining number of stalled cycles after a
  // mispredict, and the values the register file side should be showing.
  int          stallLeft;
  logic        mWv, mDv, mClr, mRdv;
  logic [4:0]  mWreg, mDreg;
  logic [31:0] mWval, mRpc, mCnt;
  logic [3:0]  mWrob, mDrob;
  logic        lastStall;

  vec_t vecs[5];

  function automatic stim_t mkStim(input logic rdy, input logic hv,
                                   input logic [3:0] hid, input logic [4:0] hrd,
                                   input logic [31:0] hval, input logic hmis,
                                   input logic [31:0] htgt, input logic rv,
                                   input logic [4:0] rrd, input logic [3:0] rid);
    stim_t s;
    s.rdy = rdy; s.hv = hv; s.hid = hid; s.hrd = hrd; s.hval = hval;
    s.hmis = hmis; s.htgt = htgt; s.rv = rv; s.rrd = rrd; s.rid = rid;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bus.rdy             = s.rdy;
    bus.head_valid      = s.hv;
    bus.head_rob_id     = s.hid;
    bus.head_rd         = s.hrd;
    bus.head_value      = s.hval;
    bus.head_mispredict = s.hmis;
    bus.head_target     = s.htgt;
    bus.ren_valid       = s.rv;
    bus.ren_rd          = s.rrd;
    bus.ren_rob_id      = s.rid;
  endtask

  task automatic modelReset();
    stallLeft = 0;
    mWv = 0; mDv = 0; mClr = 0; mRdv = 0;
    mWreg = '0; mDreg = '0; mWval = '0; mRpc = '0; mCnt = '0;
    mWrob = '0; mDrob = '0;
  endtask

  task automatic checkRegs();
    checkOutput("wb_valid", 32'(bus.need_set_reg_value), 32'(mWv));
    checkOutput("wb_reg",   32'(bus.set_value_reg_id),   32'(mWreg));
    checkOutput("wb_val",   bus.set_val,                 mWval);
    checkOutput("wb_rob",   32'(bus.set_reg_rob_id),     32'(mWrob));
    checkOutput("dep_valid", 32'(bus.need_set_reg_dep),  32'(mDv));
    checkOutput("dep_reg",  32'(bus.set_dep_reg_id),     32'(mDreg));
    checkOutput("dep_rob",  32'(bus.set_dep_rob_id),     32'(mDrob));
    checkOutput("clear",    32'(bus.clear),              32'(mClr));
    checkOutput("redir_valid", 32'(bus.redirect_valid),  32'(mRdv));
    checkOutput("redir_pc", bus.redirect_pc,             mRpc);
    checkOutput("retired",  bus.retired_cnt,             mCnt);
  endtask

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic stepModel(input stim_t s);
    logic blocked, ePop, eMisp, eStall, eAcc;
    applyStimulus(s);
    #1;
    blocked = (stallLeft > 0);
    ePop    = s.rdy & s.hv & ~blocked;
    eMisp   = ePop & s.hmis;
    eStall  = blocked | eMisp;
    eAcc    = s.rdy & s.rv & ~eStall;
    lastStall = bus.ren_stall;
    checkOutput("head_pop",  32'(bus.head_pop),  32'(ePop));
    checkOutput("ren_stall", 32'(bus.ren_stall), 32'(eStall));
    if (s.rdy) begin
      mWv = ePop && (s.hrd != 0);
      if (ePop) begin
        mWreg = s.hrd; mWval = s.hval; mWrob = s.hid; mCnt = mCnt + 1;
      end
      mDv = eAcc && (s.rrd != 0);
      if (eAcc) begin
        mDreg = s.rrd; mDrob = s.rid;
      end
      mClr = eMisp;
      mRdv = eMisp;
      if (eMisp) mRpc = s.htgt;
      if (eMisp) stallLeft = 1 + REC;
      else if (blocked) stallLeft = stallLeft - 1;
    end else begin
      mWv = 0; mDv = 0; mClr = 0; mRdv = 0;
    end
    @(posedge clk);
    #1;
    checkRegs();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkRegs();
    checkOutput("reset_stall", 32'(bus.ren_stall), 32'd0);
    checkOutput("reset_pop",   32'(bus.head_pop),  32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    int    n;

    // stim, pop, stall, wv, wreg, wval, wrob, dv, dreg, drob, clr, cnt
    vecs[0] = '{mkStim(1, 1, 4'd3, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0),
                1, 0, 1, 5'd5, 32'hDEADBEEF, 4'd3, 0, 5'd0, 4'd0, 0, 32'd1};
    vecs[1] = '{mkStim(1, 1, 4'd4, 5'd0, 32'h1234, 0, 0, 0, 0, 0),
                1, 0, 0, 5'd0, 32'h1234, 4'd4, 0, 5'd0, 4'd0, 0, 32'd2};
    vecs[2] = '{mkStim(1, 1, 4'd2, 5'd7, 32'h77, 0, 0, 1, 5'd7, 4'd9),
                1, 0, 1, 5'd7, 32'h77, 4'd2, 1, 5'd7, 4'd9, 0, 32'd3};
    vecs[3] = '{mkStim(1, 0, 4'd1, 5'd8, 32'h99, 0, 0, 1, 5'd0, 4'd5),
                0, 0, 0, 5'd7, 32'h77, 4'd2, 0, 5'd0, 4'd5, 0, 32'd3};
    vecs[4] = '{mkStim(0, 1, 4'd6, 5'd9, 32'hAA, 1, 32'h40, 1, 5'd3, 4'd8),
                0, 0, 0, 5'd7, 32'h77, 4'd2, 0, 5'd0, 4'd5, 0, 32'd3};

    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    doReset();

    $display("[TB] directed vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].s);
      #1;
      checkOutput("vec_pop",   32'(bus.head_pop),  32'(vecs[i].ePop));
      checkOutput("vec_stall", 32'(bus.ren_stall), 32'(vecs[i].eStall));
      @(posedge clk);
      #1;
      checkOutput("vec_wv",   32'(bus.need_set_reg_value), 32'(vecs[i].eWv));
      checkOutput("vec_wreg", 32'(bus.set_value_reg_id),   32'(vecs[i].eWreg));
      checkOutput("vec_wval", bus.set_val,                 vecs[i].eWval);
      checkOutput("vec_wrob", 32'(bus.set_reg_rob_id),     32'(vecs[i].eWrob));
      checkOutput("vec_dv",   32'(bus.need_set_reg_dep),   32'(vecs[i].eDv));
      checkOutput("vec_dreg", 32'(bus.set_dep_reg_id),     32'(vecs[i].eDreg));
      checkOutput("vec_drob", 32'(bus.set_dep_rob_id),     32'(vecs[i].eDrob));
      checkOutput("vec_clr",  32'(bus.clear),              32'(vecs[i].eClr));
      checkOutput("vec_cnt",  bus.retired_cnt,             vecs[i].eCnt);
      @(negedge clk);
    end

    $display("[TB] mispredict with same-cycle rename");
    doReset();
    s = mkStim(1, 1, 4'd5, 5'd1, 32'h44, 1, 32'h1000, 1, 5'd4, 4'd6);
    stepModel(s);
    checkOutput("misp_stall", 32'(lastStall), 32'd1);
    checkOutput("misp_clear", 32'(bus.clear), 32'd1);
    checkOutput("misp_pc", bus.redirect_pc, 32'h1000);
    checkOutput("misp_wb_reg", 32'(bus.set_value_reg_id), 32'd1);
    checkOutput("misp_ren_dropped", 32'(bus.need_set_reg_dep), 32'd0);
    s = mkStim(1, 1, 4'd6, 5'd2, 32'h55, 0, 0, 1, 5'd4, 4'd7);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      stepModel(s);
      if (!lastStall) break;
      n++;
    end
    checkOutput("stall_cycles", 32'(n), 32'd3);
    checkOutput("first_rename", 32'(bus.need_set_reg_dep), 32'd1);

    $display("[TB] rdy low during recovery");
    s = mkStim(1, 1, 4'd8, 5'd0, 32'h66, 1, 32'h2000, 0, 0, 0);
    stepModel(s);
    s = mkStim(1, 1, 4'd9, 5'd3, 32'h67, 0, 0, 1, 5'd5, 4'd1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      s.rdy = !(k >= 1 && k <= 3);
      stepModel(s);
      if (!lastStall) break;
      n++;
    end
    checkOutput("stall_frozen", 32'(n), 32'd6);

    $display("[TB] retired count wrap");
    force dut.retiredCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retiredCnt_q;
    mCnt = 32'hFFFF_FFFF;
    stepModel(mkStim(1, 1, 4'd2, 5'd6, 32'h12, 0, 0, 0, 0, 0));
    checkOutput("cnt_wrap", bus.retired_cnt, 32'd0);

    $display("[TB] reset during recovery");
    stepModel(mkStim(1, 1, 4'd3, 5'd2, 32'h13, 1, 32'h3000, 0, 0, 0));
    stepModel(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    stepModel(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    doReset();
    stepModel(mkStim(1, 0, 0, 0, 0, 0, 0, 1, 5'd3, 4'd2));
    checkOutput("post_rst_stall", 32'(lastStall), 32'd0);
    checkOutput("post_rst_dep", 32'(bus.need_set_reg_dep), 32'd1);

    $display("[TB] randomized run");
    for (int k = 0; k < 400; k++) begin
      s.rdy  = ($urandom_range(0, 9) != 0);
      s.hv   = ($urandom_range(0, 3) != 0);
      s.hid  = 4'($urandom);
      s.hrd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.hval = $urandom;
      s.hmis = ($urandom_range(0, 11) == 0);
      s.htgt = $urandom;
      s.rv   = ($urandom_range(0, 2) != 0);
      s.rrd  = ($urandom_range(0, 3) == 0) ? s.hrd : 5'($urandom_range(0, 31));
      s.rid  = 4'($urandom);
      stepModel(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_commit_ctrl.md
# reg_commit_ctrl

Sequences retirement from the reorder buffer into the architectural register file and owns the register file's write-side controls: value write-back, rename (dependency) updates from the decoder, and the global dependency clear on misprediction. Sits between the ROB head, the decoder rename path and the register file. It also drives the fetch redirect and the post-flush rename stall.

## Interface
Parameters:
- ROB_W, 4: ROB index width; equals `robsize` from `const.v`.
- RECOVER_CYC, 2: stall cycles after a flush before renames resume (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- head_valid  in  1  ROB head entry is complete and may retire
- head_rob_id  in  ROB_W  ROB index of head
- head_rd  in  5  destination register (0 = none)
- head_value  in  32  result value
- head_mispredict  in  1  head is a mispredicted branch/jump
- head_target  in  32  correct PC for a mispredict
- head_pop  out  1  head consumed this cycle (combinational)
- ren_valid  in  1  decoder requests rename of ren_rd
- ren_rd  in  5  renamed register
- ren_rob_id  in  ROB_W  ROB index allocated
- ren_stall  out  1  decoder must not issue
- need_set_reg_value  out  1  regfile value write
- set_value_reg_id  out  5  write register
- set_val  out  32  write data
- set_reg_rob_id  out  ROB_W  retiring ROB index
- need_set_reg_dep  out  1  regfile dependency write
- set_dep_reg_id  out  5  renamed register
- set_dep_rob_id  out  ROB_W  new producer
- clear  out  1  flush all dependencies
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  32  redirect address
- retired_cnt  out  32  retired instruction count

## Operation
- States: RUN, FLUSH, RECOVER.
- RUN: head_pop = rdy & head_valid. On pop, write-back outputs registered next cycle: need_set_reg_value = (head_rd != 0), fields copied. retired_cnt += 1 (wraps at 2^32).
- Pop with head_mispredict = 1: write-back still occurs (link register), redirect_valid=1, redirect_pc=head_target, clear=1 registered together; next state FLUSH.
- Rename pass-through in RUN: need_set_reg_dep = ren_valid & (ren_rd != 0) & !ren_stall, registered one cycle; fields copied.
- Same-cycle commit and rename of same register: both forwarded unchanged; regfile resolves ordering.
- Rename arriving in the mispredict pop cycle is dropped (wrong path).
- FLUSH (one cycle): clear, redirect_valid deassert; head_pop=0; ren_stall=1; load counter = RECOVER_CYC; go RECOVER.
- RECOVER: head_pop=0, ren_stall=1, counter decrements; at counter==1 go RUN (ren_stall drops on entry to RUN).
- ren_stall = 1 in FLUSH, RECOVER, and RUN cycle where mispredict pop happens (combinational).
- rdy=0: no state/counter change, head_pop=0, pulse outputs forced 0, data outputs hold.
- rst: state RUN, all 1-bit outputs 0, all data outputs 0, retired_cnt 0, counter 0. Reset mid-FLUSH/RECOVER returns to RUN with no pending pulse.

## Timing
- Write-back latency: 1 cycle after head_pop.
- Rename latency: 1 cycle after accepted ren_valid.
- clear, redirect_valid: single-cycle pulses, cycle after mispredict pop.
- Mispredict pop to first accepted rename: 1 + 1 + RECOVER_CYC cycles (4 at default).
- Max one retirement per cycle; back-to-back pops sustained in RUN.

## Structure
- State encoding and RECOVER_CYC default go in the shared `const.v` alongside `robsize`.
- No sub-module; single always block plus combinational pop/stall logic.

## Test plan
- Reset, then head_valid with rd=5, value 0xDEADBEEF, rob 3 -> next cycle need_set_reg_value=1, reg 5, val 0xDEADBEEF, rob 3; retired_cnt=1.
- Commit with rd=0 -> head_pop=1, need_set_reg_value=0, retired_cnt increments.
- ren_valid rd=7 rob 9 concurrent with commit rd=7 rob 2 -> next cycle both writes asserted with respective ids.
- Mispredict pop, target 0x1000, rd=1 -> next cycle clear=1, redirect_pc=0x1000, write x1; ren_stall high 3 cycles after pop cycle; rename dropped in pop cycle.
- rdy low for 3 cycles during RECOVER -> counter frozen, stall extends by 3 cycles, no pulses.
- retired_cnt preset near 0xFFFFFFFF via 1 commit after forcing -> wraps to 0; rst during RECOVER -> RUN, ren_stall=0 next cycle.
